mod_lsu: RTL and testbench
==========================

# mod_lsu

Load/store unit forming the memory stage directly downstream of the execute ALU. It accepts LOAD/STORE operations carrying the ALU effective address and the store data. It drives a request/grant/response data-memory port with byte enables, then returns sign/zero-extended load data to writeback, or raises an exception. The unit is single-outstanding: one operation in flight at a time, backpressuring execute through `ready_o`.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles without `dmem_gnt_i` or `dmem_rvalid_i` before an access fault is raised; 0 disables the timeout.
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  execute presents an operation.
- `ready_o`  out  1  unit can accept; high only in IDLE.
- `flush_i`  in  1  kill the in-flight operation (pipeline redirect).
- `opcode_i`  in  `OPCODE_WIDTH`  OP_LOAD or OP_STORE; other opcodes are ignored.
- `funct3_i`  in  `FUNCT3_WIDTH`  access width/sign.
- `addr_i`  in  `XLEN`  effective address (ALU result).
- `store_data_i`  in  `XLEN`  rs2 value.
- `rd_i`  in  5  load destination register.
- `dmem_req_o`  out  1  request valid; held until grant.
- `dmem_we_o`  out  1  1 = store.
- `dmem_be_o`  out  4  byte enables.
- `dmem_addr_o`  out  `XLEN`  word address, bits [1:0] = 0.
- `dmem_wdata_o`  out  `XLEN`  lane-replicated store data.
- `dmem_gnt_i`  in  1  request accepted.
- `dmem_rvalid_i`  in  1  response valid (loads and stores).
- `dmem_rdata_i`  in  `XLEN`  read word.
- `dmem_err_i`  in  1  bus error, qualified by `dmem_rvalid_i`.
- `wb_valid_o`  out  1  one-cycle pulse: load result valid.
- `wb_rd_o`  out  5  destination register.
- `wb_data_o`  out  `XLEN`  extended load data.
- `store_done_o`  out  1  one-cycle pulse: store completed.
- `exc_valid_o`  out  1  one-cycle exception pulse.
- `exc_cause_o`  out  2  0 load-misaligned, 1 store-misaligned, 2 access fault, 3 illegal width.
- `exc_addr_o`  out  `XLEN`  faulting `addr_i`.

## Operation
- **Reset:** state IDLE; all outputs 0 except `ready_o` = 1; timeout counter 0.
- **States:** IDLE, REQ, WAIT.
- **IDLE:** accept on `valid_i & ready_o` when the opcode is LOAD/STORE.
  - Decode width from `funct3_i`. LB/LBU/SB: any address. LH/LHU/SH: `addr[0]` = 0. LW/SW: `addr[1:0]` = 0.
  - Illegal funct3 (LOAD 3, 6, 7; STORE ≥ 3): pulse exception, cause 3, next cycle; remain IDLE.
  - Otherwise latch the operation and go to REQ.
- **REQ:** `dmem_req_o` = 1 with stable address, enables and data.
  - `dmem_gnt_i`: go to WAIT.
  - `flush_i` before grant: drop the request, go to IDLE, no outputs.
- **WAIT:** on `dmem_rvalid_i`, go to IDLE.
  - `dmem_err_i`: exception, cause 2.
  - Otherwise a load pulses `wb_valid_o`; a store pulses `store_done_o`.
  - `flush_i` in WAIT sets a kill flag. The response is still consumed, but all result and exception pulses are suppressed.
- **Byte enables:** SB `0001 << a[1:0]`, SH `0011 << {a[1],1'b0}`, SW `1111`. Loads use the same enables.
- **Store data:** SB `{4{b}}`, SH `{2{h}}`, SW word.
- **Load data:** `rdata >> (a[1:0]*8)`, then extend to `XLEN` (LB/LH sign, LBU/LHU zero).
- **Timeout:** the counter increments in REQ and WAIT and clears on state change. Reaching `TIMEOUT_CYCLES` gives exception cause 2 and a return to IDLE; a later stray `rvalid` is ignored in IDLE.
- **Simultaneous events:** `flush_i` with `dmem_gnt_i` in REQ → go to WAIT with the kill flag set. `flush_i` with `valid_i` in IDLE → the operation is not accepted.

## Timing
- Accept at cycle N → `dmem_req_o` high at N+1.
- Grant at N+1 and `rvalid` at N+2 → `wb_valid_o` / `store_done_o` at N+3 (registered), `ready_o` high at N+3.
- Best-case throughput is one operation per 3 cycles.
- Exception pulses for misaligned or illegal operations occur at N+1.
- All outputs are registered except `ready_o` (decoded from state).

## Configuration
- `LSU_MISALIGNED_TRAP_EN` defined: misaligned accesses raise cause 0/1 and are not issued.
- Undefined: misaligned addresses are silently aligned down to the access width (`a[0]` cleared for halfwords, `a[1:0]` for words) and issued normally; causes 0/1 never occur.

## Structure
- `lsu_pkg` holds:
  - the state enum `lsu_state_e`;
  - the exception cause enum `lsu_exc_e`;
  - the load/store funct3 width constants (LB..LHU, SB..SW);
  - `lsu_width_e`.
- The sub-module `mod_lsu_align` is purely combinational. It produces enables and store data from width and address, and the extended load result from the read word, width and offset.

## Test plan
- SW at addr 0x100, data 0xDEADBEEF, grant immediate → `be` = 1111, `addr` 0x100, `store_done_o` at N+3.
- LB at 0x103, rdata 0x80xxxxxx → `wb_data_o` = 0xFFFFFF80; LBU at the same address → 0x00000080.
- SH at 0x102, data 0x1234 → `be` = 1100, `wdata` = 0x12341234; LHU at 0x102, rdata 0xABCD0000 → 0x0000ABCD.
- LW at 0x101 with the macro defined → cause 0, `exc_addr_o` 0x101, no `dmem_req_o`. Without the macro → issued to 0x100.
- Grant withheld for 255 cycles → cause 2 at timeout. `dmem_err_i` with `rvalid` → cause 2, no `wb_valid_o`.
- `flush_i` in WAIT, then `rvalid` → no pulses, `ready_o` returns high. `rst_ni` low mid-REQ → `dmem_req_o` 0 immediately.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// The LSU_MISALIGNED_TRAP_EN macro does not affect this package.
package lsu_pkg;
  localparam int XLEN         = 32;
  localparam int OPCODE_WIDTH = 7;
  localparam int FUNCT3_WIDTH = 3;

  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD  = 7'b0000011;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE = 7'b0100011;

  localparam logic [FUNCT3_WIDTH-1:0] F3_LB  = 3'd0;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LH  = 3'd1;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LW  = 3'd2;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LBU = 3'd4;
  localparam logic [FUNCT3_WIDTH-1:0] F3_LHU = 3'd5;
  localparam logic [FUNCT3_WIDTH-1:0] F3_SB  = 3'd0;
  localparam logic [FUNCT3_WIDTH-1:0] F3_SH  = 3'd1;
  localparam logic [FUNCT3_WIDTH-1:0] F3_SW  = 3'd2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} lsu_state_e;

  typedef enum logic [1:0] {
    EXC_LD_MISALIGN = 2'd0,
    EXC_ST_MISALIGN = 2'd1,
    EXC_ACCESS      = 2'd2,
    EXC_ILLEGAL     = 2'd3
  } lsu_exc_e;

  typedef enum logic [1:0] {WID_B, WID_H, WID_W} lsu_width_e;
endpackage

// File: rtl/mod_lsu_align.sv
// Combinational lane steering: byte enables and replicated store data on the
// request side, shift and sign/zero extension on the response side.
module mod_lsu_align
  import lsu_pkg::*;
(
  input  lsu_width_e      i_st_width,
  input  logic [1:0]      i_st_off,
  input  logic [XLEN-1:0] i_st_data,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  input  lsu_width_e      i_ld_width,
  input  logic            i_ld_uns,
  input  logic [1:0]      i_ld_off,
  input  logic [XLEN-1:0] i_rdata,
  output logic [XLEN-1:0] o_ldata
);
  logic [XLEN-1:0] w_shift;

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_st_data;
    case (i_st_width)
      WID_B: begin
        o_be    = 4'b0001 << i_st_off;
        o_wdata = {4{i_st_data[7:0]}};
      end
      WID_H: begin
        o_be    = 4'b0011 << {i_st_off[1], 1'b0};
        o_wdata = {2{i_st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign w_shift = i_rdata >> {i_ld_off, 3'b000};

  always_comb begin
    o_ldata = w_shift;
    case (i_ld_width)
      WID_B:   o_ldata = {{(XLEN-8){~i_ld_uns & w_shift[7]}}, w_shift[7:0]};
      WID_H:   o_ldata = {{(XLEN-16){~i_ld_uns & w_shift[15]}}, w_shift[15:0]};
      default: ;
    endcase
  end
endmodule

// File: rtl/mod_lsu.sv
// Single-outstanding load/store unit with req/gnt/rvalid data-memory port.
// Define LSU_MISALIGNED_TRAP_EN to trap misaligned accesses instead of aligning them down.
module mod_lsu
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    flush_i,
  input  logic [OPCODE_WIDTH-1:0] opcode_i,
  input  logic [FUNCT3_WIDTH-1:0] funct3_i,
  input  logic [XLEN-1:0]         addr_i,
  input  logic [XLEN-1:0]         store_data_i,
  input  logic [4:0]              rd_i,
  output logic                    dmem_req_o,
  output logic                    dmem_we_o,
  output logic [3:0]              dmem_be_o,
  output logic [XLEN-1:0]         dmem_addr_o,
  output logic [XLEN-1:0]         dmem_wdata_o,
  input  logic                    dmem_gnt_i,
  input  logic                    dmem_rvalid_i,
  input  logic [XLEN-1:0]         dmem_rdata_i,
  input  logic                    dmem_err_i,
  output logic                    wb_valid_o,
  output logic [4:0]              wb_rd_o,
  output logic [XLEN-1:0]         wb_data_o,
  output logic                    store_done_o,
  output logic                    exc_valid_o,
  output logic [1:0]              exc_cause_o,
  output logic [XLEN-1:0]         exc_addr_o
);
  lsu_state_e      r_state, w_state_nxt;
  logic [31:0]     r_cnt;
  logic            r_kill, r_uns;
  lsu_width_e      r_width;
  logic [1:0]      r_off;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_addr;

  logic            w_is_load, w_is_store, w_illegal, w_uns, w_mis_trap;
  lsu_width_e      w_width;
  logic [XLEN-1:0] w_addr_eff, w_wdata, w_ldata;
  logic [3:0]      w_be;
  logic            w_accept, w_idle_exc, w_timeout, w_cnt_hit, w_kill;
  lsu_exc_e        w_idle_cause;

  assign w_is_load  = (opcode_i == OP_LOAD);
  assign w_is_store = (opcode_i == OP_STORE);
  assign ready_o    = (r_state == S_IDLE);
  assign w_cnt_hit  = (TIMEOUT_CYCLES != 0) && (r_cnt == TIMEOUT_CYCLES - 1);
  assign w_kill     = r_kill | flush_i;

  always_comb begin
    w_width   = WID_B;
    w_uns     = 1'b0;
    w_illegal = 1'b0;
    if (w_is_load) begin
      case (funct3_i)
        F3_LB:   w_width = WID_B;
        F3_LH:   w_width = WID_H;
        F3_LW:   w_width = WID_W;
        F3_LBU:  begin w_width = WID_B; w_uns = 1'b1; end
        F3_LHU:  begin w_width = WID_H; w_uns = 1'b1; end
        default: w_illegal = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        F3_SB:   w_width = WID_B;
        F3_SH:   w_width = WID_H;
        F3_SW:   w_width = WID_W;
        default: w_illegal = 1'b1;
      endcase
    end
  end

`ifdef LSU_MISALIGNED_TRAP_EN
  assign w_mis_trap = ((w_width == WID_H) && addr_i[0]) ||
                      ((w_width == WID_W) && (addr_i[1:0] != 2'b00));
  assign w_addr_eff = addr_i;
`else
  logic [1:0] w_lo;
  assign w_lo       = (w_width == WID_W) ? 2'b00 :
                      (w_width == WID_H) ? {addr_i[1], 1'b0} : addr_i[1:0];
  assign w_mis_trap = 1'b0;
  assign w_addr_eff = {addr_i[XLEN-1:2], w_lo};
`endif

  mod_lsu_align u_align (
    .i_st_width (w_width),
    .i_st_off   (w_addr_eff[1:0]),
    .i_st_data  (store_data_i),
    .o_be       (w_be),
    .o_wdata    (w_wdata),
    .i_ld_width (r_width),
    .i_ld_uns   (r_uns),
    .i_ld_off   (r_off),
    .i_rdata    (dmem_rdata_i),
    .o_ldata    (w_ldata)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    w_idle_exc   = 1'b0;
    w_idle_cause = EXC_ILLEGAL;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (valid_i && !flush_i && (w_is_load || w_is_store)) begin
          if (w_illegal) begin
            w_idle_exc = 1'b1;
          end else if (w_mis_trap) begin
            w_idle_exc   = 1'b1;
            w_idle_cause = w_is_load ? EXC_LD_MISALIGN : EXC_ST_MISALIGN;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (dmem_gnt_i) begin
          w_state_nxt = S_WAIT;
        end else if (flush_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT: begin
        if (dmem_rvalid_i) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_kill       <= 1'b0;
      r_uns        <= 1'b0;
      r_width      <= WID_B;
      r_off        <= '0;
      r_rd         <= '0;
      r_addr       <= '0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_be_o    <= '0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      wb_valid_o   <= 1'b0;
      wb_rd_o      <= '0;
      wb_data_o    <= '0;
      store_done_o <= 1'b0;
      exc_valid_o  <= 1'b0;
      exc_cause_o  <= '0;
      exc_addr_o   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      wb_valid_o   <= 1'b0;
      store_done_o <= 1'b0;
      exc_valid_o  <= 1'b0;
      r_cnt <= ((w_state_nxt != r_state) || (r_state == S_IDLE)) ? '0 : r_cnt + 32'd1;

      if (w_idle_exc) begin
        exc_valid_o <= 1'b1;
        exc_cause_o <= w_idle_cause;
        exc_addr_o  <= addr_i;
      end

      if (w_accept) begin
        dmem_req_o   <= 1'b1;
        dmem_we_o    <= w_is_store;
        dmem_be_o    <= w_be;
        dmem_addr_o  <= {w_addr_eff[XLEN-1:2], 2'b00};
        dmem_wdata_o <= w_wdata;
        r_width      <= w_width;
        r_uns        <= w_uns;
        r_off        <= w_addr_eff[1:0];
        r_rd         <= rd_i;
        r_addr       <= addr_i;
        r_kill       <= 1'b0;
      end

      if ((r_state == S_REQ) && (w_state_nxt != S_REQ)) dmem_req_o <= 1'b0;
      if ((r_state != S_IDLE) && flush_i) r_kill <= 1'b1;

      // A killed operation still retires through the FSM but reports nothing.
      if ((r_state == S_WAIT) && dmem_rvalid_i && !w_kill) begin
        if (dmem_err_i) begin
          exc_valid_o <= 1'b1;
          exc_cause_o <= EXC_ACCESS;
          exc_addr_o  <= r_addr;
        end else if (dmem_we_o) begin
          store_done_o <= 1'b1;
        end else begin
          wb_valid_o <= 1'b1;
          wb_rd_o    <= r_rd;
          wb_data_o  <= w_ldata;
        end
      end

      if (w_timeout && !w_kill) begin
        exc_valid_o <= 1'b1;
        exc_cause_o <= EXC_ACCESS;
        exc_addr_o  <= r_addr;
      end
    end
  end
endmodule

// File: tb/tb_mod_lsu.sv
// Directed bench for mod_lsu: aligned/unaligned loads and stores, exceptions,
// timeout, flush and asynchronous reset.
module tb_mod_lsu;
  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        valid_i, ready_o, flush_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i, store_data_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o, dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_gnt_i, dmem_rvalid_i, dmem_err_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        store_done_o, exc_valid_o;
  logic [1:0]  exc_cause_o;
  logic [31:0] exc_addr_o;

  int checks = 0;
  int errors = 0;

  logic        cap_req, cap_we;
  logic [3:0]  cap_be;
  logic [31:0] cap_addr, cap_wdata;
  int          n;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  mod_lsu #(.TIMEOUT_CYCLES(255)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .store_data_i(store_data_i), .rd_i(rd_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_be_o(dmem_be_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
    .dmem_rdata_i(dmem_rdata_i), .dmem_err_i(dmem_err_i), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .store_done_o(store_done_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_addr_o(exc_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one operation for a cycle and captures the request at N+1.
  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd);
    valid_i = 1'b1; opcode_i = op; funct3_i = f3; addr_i = a; store_data_i = sd; rd_i = 5'd7;
    tick();
    valid_i   = 1'b0;
    cap_req   = dmem_req_o;
    cap_we    = dmem_we_o;
    cap_be    = dmem_be_o;
    cap_addr  = dmem_addr_o;
    cap_wdata = dmem_wdata_o;
  endtask

  // Full transaction with immediate grant and response; ends at N+3.
  task automatic access(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] sd, input logic [31:0] rword, input logic err);
    issue(op, f3, a, sd);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = rword; dmem_err_i = err;
    tick();
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; opcode_i = '0; funct3_i = '0;
    addr_i = '0; store_data_i = '0; rd_i = '0; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    dmem_rdata_i = '0; dmem_err_i = 1'b0;
    tick(); tick();
    chk("rst_ready", ready_o, 1);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_wbv", wb_valid_o, 0);
    chk("rst_sdone", store_done_o, 0);
    chk("rst_exc", exc_valid_o, 0);
    rst_ni = 1'b1;
    tick();

    // SW 0x100
    access(ST, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    chk("sw_req", cap_req, 1);
    chk("sw_we", cap_we, 1);
    chk("sw_be", cap_be, 4'b1111);
    chk("sw_addr", cap_addr, 32'h100);
    chk("sw_wdata", cap_wdata, 32'hDEADBEEF);
    chk("sw_done", store_done_o, 1);
    chk("sw_ready", ready_o, 1);
    chk("sw_wbv", wb_valid_o, 0);
    tick();
    chk("sw_done_pulse", store_done_o, 0);

    // LB / LBU at 0x103
    access(LD, 3'd0, 32'h103, 32'h0, 32'h80123456, 1'b0);
    chk("lb_be", cap_be, 4'b1000);
    chk("lb_addr", cap_addr, 32'h100);
    chk("lb_we", cap_we, 0);
    chk("lb_wbv", wb_valid_o, 1);
    chk("lb_rd", wb_rd_o, 5'd7);
    chk("lb_data", wb_data_o, 32'hFFFFFF80);
    access(LD, 3'd4, 32'h103, 32'h0, 32'h80123456, 1'b0);
    chk("lbu_data", wb_data_o, 32'h00000080);

    // SH / LHU / LH at 0x102
    access(ST, 3'd1, 32'h102, 32'h00001234, 32'h0, 1'b0);
    chk("sh_be", cap_be, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'h12341234);
    chk("sh_addr", cap_addr, 32'h100);
    access(LD, 3'd5, 32'h102, 32'h0, 32'hABCD0000, 1'b0);
    chk("lhu_data", wb_data_o, 32'h0000ABCD);
    access(LD, 3'd1, 32'h102, 32'h0, 32'hABCD0000, 1'b0);
    chk("lh_data", wb_data_o, 32'hFFFFABCD);

    // LW at misaligned 0x101
`ifdef LSU_MISALIGNED_TRAP_EN
    issue(LD, 3'd2, 32'h101, 32'h0);
    chk("lwmis_req", cap_req, 0);
    chk("lwmis_exc", exc_valid_o, 1);
    chk("lwmis_cause", exc_cause_o, 2'd0);
    chk("lwmis_addr", exc_addr_o, 32'h101);
    chk("lwmis_ready", ready_o, 1);
    tick();
`else
    access(LD, 3'd2, 32'h101, 32'h0, 32'h11223344, 1'b0);
    chk("lwmis_addr", cap_addr, 32'h100);
    chk("lwmis_be", cap_be, 4'b1111);
    chk("lwmis_data", wb_data_o, 32'h11223344);
    chk("lwmis_exc", exc_valid_o, 0);
`endif

    // Illegal load width funct3=3
    issue(LD, 3'd3, 32'h44, 32'h0);
    chk("ill_req", cap_req, 0);
    chk("ill_exc", exc_valid_o, 1);
    chk("ill_cause", exc_cause_o, 2'd3);
    chk("ill_addr", exc_addr_o, 32'h44);
    chk("ill_ready", ready_o, 1);
    tick();

    // Grant withheld: timeout
    issue(LD, 3'd2, 32'h200, 32'h0);
    n = 0;
    while (dmem_req_o && n < 300) begin
      n++;
      tick();
    end
    chk("to_cycles", n, 255);
    chk("to_exc", exc_valid_o, 1);
    chk("to_cause", exc_cause_o, 2'd2);
    chk("to_addr", exc_addr_o, 32'h200);
    chk("to_ready", ready_o, 1);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h55;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("stray_wbv", wb_valid_o, 0);
    chk("stray_exc", exc_valid_o, 0);

    // Bus error
    access(LD, 3'd2, 32'h300, 32'h0, 32'h12345678, 1'b1);
    chk("err_exc", exc_valid_o, 1);
    chk("err_cause", exc_cause_o, 2'd2);
    chk("err_addr", exc_addr_o, 32'h300);
    chk("err_wbv", wb_valid_o, 0);

    // Flush in WAIT
    issue(LD, 3'd2, 32'h400, 32'h0);
    dmem_gnt_i = 1'b1;
    tick();
    dmem_gnt_i = 1'b0; flush_i = 1'b1;
    tick();
    flush_i = 1'b0; dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h99;
    tick();
    dmem_rvalid_i = 1'b0;
    chk("fw_wbv", wb_valid_o, 0);
    chk("fw_exc", exc_valid_o, 0);
    chk("fw_ready", ready_o, 1);

    // Flush in REQ before grant
    issue(ST, 3'd2, 32'h500, 32'h1);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk("fr_req", dmem_req_o, 0);
    chk("fr_ready", ready_o, 1);
    chk("fr_sdone", store_done_o, 0);

    // Flush together with valid in IDLE
    valid_i = 1'b1; flush_i = 1'b1; opcode_i = LD; funct3_i = 3'd2; addr_i = 32'h600;
    tick();
    valid_i = 1'b0; flush_i = 1'b0;
    chk("fi_req", dmem_req_o, 0);
    chk("fi_ready", ready_o, 1);

    // Asynchronous reset while in REQ
    issue(LD, 3'd2, 32'h700, 32'h0);
    chk("ar_req_before", cap_req, 1);
    rst_ni = 1'b0;
    #1;
    chk("ar_req", dmem_req_o, 0);
    chk("ar_ready", ready_o, 1);
    tick();
    rst_ni = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
